// File: rtl/predictor_drv_if.sv
// Core-side ap_ctrl_hs handshake and read-port bundle for the predictor core.
// master: the driver (issues start, serves reads); slave: the predictor core.
interface predictor_drv_if #(
   parameter int unsigned DW = 64
);
   logic          pred_ap_start;
   logic          pred_ap_ready;
   logic          pred_ap_done;
   logic          pred_ap_idle;
   logic          xhat_address0;
   logic          xhat_ce0;
   logic [DW-1:0] xhat_q0;
   logic          xhat_address1;
   logic          xhat_ce1;
   logic [DW-1:0] xhat_q1;
   logic [DW-1:0] uk;
   logic [DW-1:0] yhat;
   logic          yhat_ap_vld;

   modport master (
      output pred_ap_start, xhat_q0, xhat_q1, uk,
      input  pred_ap_ready, pred_ap_done, pred_ap_idle,
      input  xhat_address0, xhat_ce0, xhat_address1, xhat_ce1,
      input  yhat, yhat_ap_vld
   );

   modport slave (
      input  pred_ap_start, xhat_q0, xhat_q1, uk,
      output pred_ap_ready, pred_ap_done, pred_ap_idle,
      output xhat_address0, xhat_ce0, xhat_address1, xhat_ce1,
      output yhat, yhat_ap_vld
   );
endinterface

// File: rtl/predictor_drv.sv
// Initiator for the predictor core: snapshots xhat/uk on a sample tick, pulses ap_start,
// serves the core's two read ports from the snapshot and returns yhat with a 1-cycle valid.
// Optional macro PRED_DRV_TIMEOUT_EN: abort WAIT after TIMEOUT_CYC cycles, sticky timeout.
module predictor_drv #(
   parameter int unsigned DW          = 64,
   parameter int unsigned OVR_W       = 16,
   parameter int unsigned LAT_W       = 8,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic             clk_1,
   input  logic             ap_rst_n,
   input  logic             ce_1,
   input  logic             sample_tick,
   input  logic [DW-1:0]    xhat0_in,
   input  logic [DW-1:0]    xhat1_in,
   input  logic [DW-1:0]    uk_in,
   predictor_drv_if.master  core,
   output logic [DW-1:0]    y_out,
   output logic             y_valid,
   output logic             busy,
   output logic [OVR_W-1:0] overrun_cnt,
   output logic [LAT_W-1:0] last_lat,
   output logic             timeout
);

   typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

   state_e           state_q, state_d;
   logic             start_q, start_d;
   logic [DW-1:0]    snap_x0_q, snap_x0_d;
   logic [DW-1:0]    snap_x1_q, snap_x1_d;
   logic [DW-1:0]    snap_u_q, snap_u_d;
   logic [DW-1:0]    q0_q, q0_d;
   logic [DW-1:0]    q1_q, q1_d;
   logic [DW-1:0]    y_out_q, y_out_d;
   logic             y_valid_q, y_valid_d;
   logic [OVR_W-1:0] ovr_q, ovr_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic [LAT_W-1:0] last_lat_q, last_lat_d;

`ifdef PRED_DRV_TIMEOUT_EN
   localparam int unsigned WcntW = $clog2(TIMEOUT_CYC + 1);
   logic [WcntW-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
`else
   localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
`endif

   // Handshake status the core reports but which never gates the FSM.
   logic unused_core_status;
   assign unused_core_status = core.pred_ap_done ^ core.pred_ap_idle;

   // Next-state logic for FSM, snapshots, read ports, counters and result capture.
   always_comb begin
      state_d    = state_q;
      start_d    = start_q;
      snap_x0_d  = snap_x0_q;
      snap_x1_d  = snap_x1_q;
      snap_u_d   = snap_u_q;
      q0_d       = q0_q;
      q1_d       = q1_q;
      y_out_d    = y_out_q;
      y_valid_d  = 1'b0;
      ovr_d      = ovr_q;
      lat_d      = lat_q;
      last_lat_d = last_lat_q;
`ifdef PRED_DRV_TIMEOUT_EN
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
`endif

      if (core.xhat_ce0) q0_d = core.xhat_address0 ? snap_x1_q : snap_x0_q;
      if (core.xhat_ce1) q1_d = core.xhat_address1 ? snap_x1_q : snap_x0_q;

      // Any tick seen outside IDLE is dropped, including the cycle WAIT finishes.
      if (sample_tick && (state_q != StIdle) && (ovr_q != '1)) ovr_d = ovr_q + OVR_W'(1);

      if ((state_q != StIdle) && (lat_q != '1)) lat_d = lat_q + LAT_W'(1);

      case (state_q)
         StIdle: begin
            if (sample_tick) begin
               snap_x0_d = xhat0_in;
               snap_x1_d = xhat1_in;
               snap_u_d  = uk_in;
               lat_d     = '0;
               start_d   = 1'b1;
               state_d   = StStart;
            end
         end
         StStart: begin
            if (core.pred_ap_ready) begin
               start_d = 1'b0;
               state_d = StWait;
`ifdef PRED_DRV_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
            end
         end
         StWait: begin
            if (core.yhat_ap_vld) begin
               y_out_d    = core.yhat;
               y_valid_d  = 1'b1;
               last_lat_d = lat_q;
               state_d    = StIdle;
            end
`ifdef PRED_DRV_TIMEOUT_EN
            else if (wait_cnt_q == WcntW'(TIMEOUT_CYC - 1)) begin
               timeout_d = 1'b1;
               state_d   = StIdle;
            end else begin
               wait_cnt_d = wait_cnt_q + WcntW'(1);
            end
`endif
         end
         default: begin
            state_d = StIdle;
            start_d = 1'b0;
         end
      endcase
   end

   // State register; ce_1 gates every update, reset clears everything at once.
   always_ff @(posedge clk_1 or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q    <= StIdle;
         start_q    <= 1'b0;
         snap_x0_q  <= '0;
         snap_x1_q  <= '0;
         snap_u_q   <= '0;
         q0_q       <= '0;
         q1_q       <= '0;
         y_out_q    <= '0;
         y_valid_q  <= 1'b0;
         ovr_q      <= '0;
         lat_q      <= '0;
         last_lat_q <= '0;
`ifdef PRED_DRV_TIMEOUT_EN
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
`endif
      end else if (ce_1) begin
         state_q    <= state_d;
         start_q    <= start_d;
         snap_x0_q  <= snap_x0_d;
         snap_x1_q  <= snap_x1_d;
         snap_u_q   <= snap_u_d;
         q0_q       <= q0_d;
         q1_q       <= q1_d;
         y_out_q    <= y_out_d;
         y_valid_q  <= y_valid_d;
         ovr_q      <= ovr_d;
         lat_q      <= lat_d;
         last_lat_q <= last_lat_d;
`ifdef PRED_DRV_TIMEOUT_EN
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
`endif
      end
   end

   assign core.pred_ap_start = start_q;
   assign core.xhat_q0       = q0_q;
   assign core.xhat_q1       = q1_q;
   assign core.uk            = snap_u_q;
   assign y_out              = y_out_q;
   assign y_valid            = y_valid_q;
   assign busy               = (state_q != StIdle);
   assign overrun_cnt        = ovr_q;
   assign last_lat           = last_lat_q;
`ifdef PRED_DRV_TIMEOUT_EN
   assign timeout            = timeout_q;
`else
   assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_predictor_drv.sv
// Bench for predictor_drv: directed core handshakes, scoreboard of expected results
// popped by a monitor whenever y_valid is seen.
module tb_predictor_drv;
   localparam int unsigned DW = 64;

   typedef struct {
      logic [63:0] y;
      logic [7:0]  lat;
   } exp_t;

   logic          clk_1;
   logic          ap_rst_n;
   logic          ce_1;
   logic          sample_tick;
   logic [DW-1:0] xhat0_in;
   logic [DW-1:0] xhat1_in;
   logic [DW-1:0] uk_in;
   logic [DW-1:0] y_out;
   logic          y_valid;
   logic          busy;
   logic [15:0]   overrun_cnt;
   logic [7:0]    last_lat;
   logic          timeout;

   predictor_drv_if #(.DW(DW)) core_if ();

   predictor_drv #(
      .DW          (DW),
      .OVR_W       (16),
      .LAT_W       (8),
      .TIMEOUT_CYC (64)
   ) dut (
      .clk_1       (clk_1),
      .ap_rst_n    (ap_rst_n),
      .ce_1        (ce_1),
      .sample_tick (sample_tick),
      .xhat0_in    (xhat0_in),
      .xhat1_in    (xhat1_in),
      .uk_in       (uk_in),
      .core        (core_if),
      .y_out       (y_out),
      .y_valid     (y_valid),
      .busy        (busy),
      .overrun_cnt (overrun_cnt),
      .last_lat    (last_lat),
      .timeout     (timeout)
   );

   int   checks;
   int   failures;
   exp_t sb[$];

   initial begin
      clk_1 = 1'b0;
      forever #5 clk_1 = ~clk_1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_1);
      #1;
   endtask

   task automatic push_exp(input logic [63:0] y, input logic [7:0] lat);
      exp_t e;
      e.y   = y;
      e.lat = lat;
      sb.push_back(e);
   endtask

   // Monitor: every y_valid must match the oldest expected result.
   always @(negedge clk_1) begin
      if (y_valid) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_y_valid actual=1 expected=0 y_out=%h", y_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("y_out", y_out, e.y);
            chk("last_lat", 64'(last_lat), 64'(e.lat));
         end
      end
   end

   initial begin
      checks   = 0;
      failures = 0;
      ap_rst_n = 1'b1;
      ce_1 = 1'b1;
      sample_tick = 1'b0;
      xhat0_in = '0;
      xhat1_in = '0;
      uk_in = '0;
      core_if.pred_ap_ready = 1'b0;
      core_if.pred_ap_done = 1'b0;
      core_if.pred_ap_idle = 1'b1;
      core_if.xhat_address0 = 1'b0;
      core_if.xhat_ce0 = 1'b0;
      core_if.xhat_address1 = 1'b0;
      core_if.xhat_ce1 = 1'b0;
      core_if.yhat = '0;
      core_if.yhat_ap_vld = 1'b0;
      #2 ap_rst_n = 1'b0;
      step();
      step();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_start", 64'(core_if.pred_ap_start), 64'd0);
      chk("rst_y_out", y_out, 64'd0);
      chk("rst_overrun", 64'(overrun_cnt), 64'd0);
      chk("rst_timeout", 64'(timeout), 64'd0);
      ap_rst_n = 1'b1;
      step();

      // 1: basic transaction, start held until ready, cross-addressed reads, lat 12
      xhat0_in = 64'h0000_0001_0000_0000;
      xhat1_in = 64'h0000_0002_0000_0000;
      uk_in    = 64'h0000_0000_8000_0000;
      sample_tick = 1'b1;
      step();                                   // START, lat 0
      sample_tick = 1'b0;
      chk("t1_start", 64'(core_if.pred_ap_start), 64'd1);
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_uk", core_if.uk, 64'h0000_0000_8000_0000);
      step();                                   // lat 1
      chk("t1_start_hold1", 64'(core_if.pred_ap_start), 64'd1);
      step();                                   // lat 2
      chk("t1_start_hold2", 64'(core_if.pred_ap_start), 64'd1);
      core_if.pred_ap_ready = 1'b1;
      step();                                   // WAIT, lat 3
      core_if.pred_ap_ready = 1'b0;
      chk("t1_start_drop", 64'(core_if.pred_ap_start), 64'd0);
      core_if.xhat_ce0 = 1'b1;
      core_if.xhat_address0 = 1'b1;
      core_if.xhat_ce1 = 1'b1;
      core_if.xhat_address1 = 1'b0;
      step();                                   // lat 4
      chk("t1_q0", core_if.xhat_q0, 64'h0000_0002_0000_0000);
      chk("t1_q1", core_if.xhat_q1, 64'h0000_0001_0000_0000);
      core_if.xhat_ce0 = 1'b0;
      core_if.xhat_ce1 = 1'b0;
      core_if.xhat_address0 = 1'b0;
      core_if.pred_ap_done = 1'b1;
      step();                                   // lat 5
      core_if.pred_ap_done = 1'b0;
      chk("t1_q0_hold", core_if.xhat_q0, 64'h0000_0002_0000_0000);
      chk("t1_done_ignored", 64'(busy), 64'd1);
      repeat (7) step();                        // lat 12
      core_if.yhat = 64'h5;
      core_if.yhat_ap_vld = 1'b1;
      push_exp(64'h5, 8'd12);
      step();
      core_if.yhat_ap_vld = 1'b0;
      chk("t1_idle", 64'(busy), 64'd0);
      step();
      chk("t1_valid_pulse", 64'(y_valid), 64'd0);

      // 2: overrun ticks in WAIT, frozen snapshot, tick on the returning cycle
      xhat0_in = 64'h10;
      xhat1_in = 64'h20;
      uk_in    = 64'h30;
      sample_tick = 1'b1;
      step();                                   // START, lat 0
      sample_tick = 1'b0;
      core_if.pred_ap_ready = 1'b1;
      step();                                   // WAIT, lat 1
      core_if.pred_ap_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample_tick = 1'b1;
         xhat0_in = 64'hDEAD_0000 + 64'(i);
         step();
         chk("t2_no_restart", 64'(core_if.pred_ap_start), 64'd0);
      end
      sample_tick = 1'b0;                       // lat 4
      chk("t2_overrun3", 64'(overrun_cnt), 64'd3);
      core_if.xhat_ce0 = 1'b1;
      core_if.xhat_address0 = 1'b0;
      step();                                   // lat 5
      core_if.xhat_ce0 = 1'b0;
      chk("t2_snap_x0", core_if.xhat_q0, 64'h10);
      chk("t2_snap_u", core_if.uk, 64'h30);
      core_if.yhat = 64'h1234;
      core_if.yhat_ap_vld = 1'b1;
      sample_tick = 1'b1;
      push_exp(64'h1234, 8'd5);
      step();
      core_if.yhat_ap_vld = 1'b0;
      sample_tick = 1'b0;
      chk("t2_overrun_edge", 64'(overrun_cnt), 64'd4);
      chk("t2_no_new_run", 64'(busy), 64'd0);

      // 3: ce_1 low freezes FSM, lat and read data; vld under ce_1=0 is dropped
      xhat0_in = 64'hAAAA;
      xhat1_in = 64'hBBBB;
      sample_tick = 1'b1;
      step();                                   // START, lat 0
      sample_tick = 1'b0;
      core_if.pred_ap_ready = 1'b1;
      step();                                   // WAIT, lat 1
      core_if.pred_ap_ready = 1'b0;
      core_if.xhat_ce0 = 1'b1;
      core_if.xhat_address0 = 1'b1;
      step();                                   // lat 2
      chk("t3_q0", core_if.xhat_q0, 64'hBBBB);
      ce_1 = 1'b0;
      core_if.xhat_address0 = 1'b0;
      core_if.yhat = 64'hBAD;
      core_if.yhat_ap_vld = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_busy_hold", 64'(busy), 64'd1);
         chk("t3_q0_hold", core_if.xhat_q0, 64'hBBBB);
         chk("t3_no_valid", 64'(y_valid), 64'd0);
      end
      ce_1 = 1'b1;
      core_if.yhat_ap_vld = 1'b0;
      core_if.xhat_ce0 = 1'b0;
      step();                                   // lat 3
      core_if.yhat = 64'h77;
      core_if.yhat_ap_vld = 1'b1;
      push_exp(64'h77, 8'd3);
      step();
      core_if.yhat_ap_vld = 1'b0;

      // 4: asynchronous reset mid-WAIT, then stray vld in IDLE
      xhat0_in = 64'h1111;
      xhat1_in = 64'h2222;
      uk_in    = 64'h3333;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      core_if.pred_ap_ready = 1'b1;
      step();                                   // WAIT
      core_if.pred_ap_ready = 1'b0;
      #2 ap_rst_n = 1'b0;
      #1;
      chk("t4_busy", 64'(busy), 64'd0);
      chk("t4_y_out", y_out, 64'd0);
      chk("t4_last_lat", 64'(last_lat), 64'd0);
      chk("t4_overrun", 64'(overrun_cnt), 64'd0);
      chk("t4_uk", core_if.uk, 64'd0);
      chk("t4_q0", core_if.xhat_q0, 64'd0);
      step();
      ap_rst_n = 1'b1;
      step();
      core_if.yhat = 64'hEE;
      core_if.yhat_ap_vld = 1'b1;
      step();
      core_if.yhat_ap_vld = 1'b0;
      chk("t4_stray_vld", 64'(y_valid), 64'd0);
      chk("t4_stray_busy", 64'(busy), 64'd0);

      // 5: overrun and latency saturation
      sample_tick = 1'b1;
      step();                                   // START
      core_if.pred_ap_ready = 1'b1;
      step();                                   // WAIT
      core_if.pred_ap_ready = 1'b0;
      repeat (65540) step();
      chk("t5_overrun_sat", 64'(overrun_cnt), 64'hFFFF);
      sample_tick = 1'b0;
      core_if.yhat = 64'h99;
      core_if.yhat_ap_vld = 1'b1;
      push_exp(64'h99, 8'hFF);
      step();
      core_if.yhat_ap_vld = 1'b0;
      chk("t5_overrun_stay", 64'(overrun_cnt), 64'hFFFF);

      // 6: no vld for a long WAIT
`ifdef PRED_DRV_TIMEOUT_EN
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      core_if.pred_ap_ready = 1'b1;
      step();                                   // WAIT cycle 1
      core_if.pred_ap_ready = 1'b0;
      repeat (63) step();                       // WAIT cycle 64
      chk("t6_pre_busy", 64'(busy), 64'd1);
      chk("t6_pre_timeout", 64'(timeout), 64'd0);
      step();
      chk("t6_abort_idle", 64'(busy), 64'd0);
      chk("t6_timeout", 64'(timeout), 64'd1);
      chk("t6_no_valid", 64'(y_valid), 64'd0);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      chk("t6_restart", 64'(core_if.pred_ap_start), 64'd1);
      core_if.pred_ap_ready = 1'b1;
      step();                                   // lat 1
      core_if.pred_ap_ready = 1'b0;
      core_if.yhat = 64'h42;
      core_if.yhat_ap_vld = 1'b1;
      push_exp(64'h42, 8'd1);
      step();
      core_if.yhat_ap_vld = 1'b0;
      chk("t6_sticky", 64'(timeout), 64'd1);
`else
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      core_if.pred_ap_ready = 1'b1;
      step();                                   // lat 1
      core_if.pred_ap_ready = 1'b0;
      repeat (100) step();                      // lat 101
      chk("t6_still_wait", 64'(busy), 64'd1);
      chk("t6_timeout_off", 64'(timeout), 64'd0);
      core_if.yhat = 64'h42;
      core_if.yhat_ap_vld = 1'b1;
      push_exp(64'h42, 8'd101);
      step();
      core_if.yhat_ap_vld = 1'b0;
`endif

      step();
      step();
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
